// File: rtl/controller_number_reg_pkg.sv
// Shared opcode encoding and default sizing for the calculator number register.
package controller_number_reg_pkg;

    localparam int unsigned CN_N           = 3;
    localparam int unsigned CD_N_DEF       = 32;
    localparam int unsigned MAX_DIGITS_DEF = 9;
    localparam int unsigned UNDO_DEPTH_DEF = 4;

    // Per-cycle opcode issued by the controller FSM; encoding 7 is unused and holds.
    typedef enum logic [CN_N-1:0] {
        CN_HOLD    = 3'd0,
        CN_CLEAR   = 3'd1,
        CN_DIGIT   = 3'd2,
        CN_BACK    = 3'd3,
        CN_NEG     = 3'd4,
        CN_LOAD_AL = 3'd5,
        CN_LOAD_DT = 3'd6
    } cn_op_e;

endpackage

// File: rtl/controller_undo_lifo.sv
// Circular backspace history: push overwrites the oldest entry when full.
module controller_undo_lifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_ptr;
    logic [PW-1:0] nxt_ptr;
    logic [CW-1:0] count;

    // Wrap-around neighbours of the write pointer.
    always_comb begin
        top_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
        nxt_ptr = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    end

    assign dout  = mem[top_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and saturating occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= nxt_ptr;
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= top_ptr;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/controller_number_reg.sv
// Registered operand register: digit entry, sign toggle, undo history and loads.
module controller_number_reg
    import controller_number_reg_pkg::*;
#(
    parameter int unsigned CD_N       = CD_N_DEF,
    parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int unsigned UNDO_DEPTH = UNDO_DEPTH_DEF
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [CN_N-1:0]                 num_op,
    input  logic [3:0]                      digit,
    input  logic [CD_N-1:0]                 al_C,
    input  logic [CD_N-1:0]                 dt_data,
    output logic [CD_N-1:0]                 number_Q,
    output logic [$clog2(MAX_DIGITS+1)-1:0] digit_cnt,
    output logic                            entry_active,
    output logic                            overflow,
    output logic                            undo_empty
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned XW    = CD_N + 4;
    localparam logic [XW-1:0]   LIMIT    = {5'b0, {(CD_N-1){1'b1}}};
    localparam logic [CD_N-1:0] MOST_NEG = {1'b1, {(CD_N-1){1'b0}}};

    logic [CD_N-1:0]  mag_q;
    logic             neg_q;
    logic [CD_N-1:0]  mag_d;
    logic             neg_d;
    logic [CNT_W-1:0] cnt_d;
    logic             act_d;
    logic             ovf_d;
    logic [CD_N-1:0]  num_d;
    logic [CD_N-1:0]  load_v;
    logic [XW-1:0]    mag_ext;
    logic [XW-1:0]    mag_x10;
    logic             lifo_push;
    logic             lifo_pop;
    logic             lifo_flush;
    logic [CD_N-1:0]  lifo_dout;
    logic             lifo_full_unused;

    // Candidate value after appending the digit, wide enough to never wrap.
    always_comb begin
        mag_ext = {4'b0, mag_q};
        mag_x10 = (mag_ext << 3) + (mag_ext << 1) + XW'(digit);
    end

    // Next-state decode of the per-cycle opcode.
    always_comb begin
        mag_d      = mag_q;
        neg_d      = neg_q;
        cnt_d      = digit_cnt;
        act_d      = entry_active;
        ovf_d      = overflow;
        lifo_push  = 1'b0;
        lifo_pop   = 1'b0;
        lifo_flush = 1'b0;
        load_v     = (num_op == CN_LOAD_AL) ? al_C : dt_data;
        case (num_op)
            CN_CLEAR: begin
                mag_d      = '0;
                neg_d      = 1'b0;
                cnt_d      = '0;
                act_d      = 1'b0;
                ovf_d      = 1'b0;
                lifo_flush = 1'b1;
            end
            CN_DIGIT: begin
                if (digit > 4'd9) begin
                    ovf_d = 1'b1;
                end else if (!entry_active) begin
                    mag_d      = CD_N'(digit);
                    neg_d      = 1'b0;
                    cnt_d      = (digit != 4'd0) ? CNT_W'(1) : '0;
                    act_d      = 1'b1;
                    ovf_d      = 1'b0;
                    lifo_flush = 1'b1;
                end else if (digit_cnt == '0 && digit == 4'd0) begin
                    mag_d = mag_q;
                end else if (digit_cnt == CNT_W'(MAX_DIGITS) || mag_x10 > LIMIT) begin
                    ovf_d = 1'b1;
                end else begin
                    lifo_push = 1'b1;
                    mag_d     = mag_x10[CD_N-1:0];
                    cnt_d     = digit_cnt + CNT_W'(1);
                end
            end
            CN_BACK: begin
                if (!undo_empty && digit_cnt != '0) begin
                    lifo_pop = 1'b1;
                    mag_d    = lifo_dout;
                    cnt_d    = digit_cnt - CNT_W'(1);
                end else if (digit_cnt != '0) begin
                    mag_d = '0;
                    cnt_d = '0;
                end
            end
            CN_NEG: begin
                if (neg_q && mag_q == MOST_NEG) begin
                    ovf_d = 1'b1;
                end else if (mag_q == '0) begin
                    neg_d = 1'b0;
                end else begin
                    neg_d = ~neg_q;
                end
            end
            CN_LOAD_AL, CN_LOAD_DT: begin
                neg_d      = load_v[CD_N-1];
                mag_d      = load_v[CD_N-1] ? (~load_v + CD_N'(1)) : load_v;
                cnt_d      = '0;
                act_d      = 1'b0;
                ovf_d      = 1'b0;
                lifo_flush = 1'b1;
            end
            default: begin
                mag_d = mag_q;
            end
        endcase
        num_d = neg_d ? (~mag_d + CD_N'(1)) : mag_d;
    end

    // State and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mag_q        <= '0;
            neg_q        <= 1'b0;
            digit_cnt    <= '0;
            entry_active <= 1'b0;
            overflow     <= 1'b0;
            number_Q     <= '0;
        end else begin
            mag_q        <= mag_d;
            neg_q        <= neg_d;
            digit_cnt    <= cnt_d;
            entry_active <= act_d;
            overflow     <= ovf_d;
            number_Q     <= num_d;
        end
    end

    controller_undo_lifo #(
        .W     (CD_N),
        .DEPTH (UNDO_DEPTH)
    ) u_undo (
        .clk   (Clock),
        .rst_n (Reset),
        .push  (lifo_push),
        .pop   (lifo_pop),
        .flush (lifo_flush),
        .din   (mag_q),
        .dout  (lifo_dout),
        .empty (undo_empty),
        .full  (lifo_full_unused)
    );

endmodule

// File: tb/tb_controller_number_reg.sv
// Directed bench for controller_number_reg with a behavioural model feeding a scoreboard.
module tb_controller_number_reg;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  num_op = 3'd0;
    logic [3:0]  digit = 4'd0;
    logic [31:0] al_C = 32'd0;
    logic [31:0] dt_data = 32'd0;

    logic [31:0] number_Q_a, number_Q_b;
    logic [3:0]  digit_cnt_a, digit_cnt_b;
    logic        entry_active_a, entry_active_b;
    logic        overflow_a, overflow_b;
    logic        undo_empty_a, undo_empty_b;

    always #5 Clock = ~Clock;

    controller_number_reg dut_a (
        .Clock(Clock), .Reset(Reset), .num_op(num_op), .digit(digit),
        .al_C(al_C), .dt_data(dt_data), .number_Q(number_Q_a),
        .digit_cnt(digit_cnt_a), .entry_active(entry_active_a),
        .overflow(overflow_a), .undo_empty(undo_empty_a)
    );

    controller_number_reg #(.MAX_DIGITS(10)) dut_b (
        .Clock(Clock), .Reset(Reset), .num_op(num_op), .digit(digit),
        .al_C(al_C), .dt_data(dt_data), .number_Q(number_Q_b),
        .digit_cnt(digit_cnt_b), .entry_active(entry_active_b),
        .overflow(overflow_b), .undo_empty(undo_empty_b)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] cnt;
        logic        act;
        logic        ovf;
        logic        ue;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model of dut_a (MAX_DIGITS 9, UNDO_DEPTH 4).
    logic [31:0] m_mag = 32'd0;
    logic        m_neg = 1'b0;
    int          m_cnt = 0;
    logic        m_act = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_lifo[$];

    task automatic model_reset();
        m_mag = 32'd0; m_neg = 1'b0; m_cnt = 0; m_act = 1'b0; m_ovf = 1'b0;
        m_lifo.delete();
    endtask

    task automatic model_op(input logic [2:0] op, input logic [3:0] d, input logic [31:0] v);
        logic [63:0] nx;
        nx = 64'(m_mag) * 64'd10 + 64'(d);
        case (op)
            3'd1: model_reset();
            3'd2: begin
                if (d > 4'd9) m_ovf = 1'b1;
                else if (!m_act) begin
                    m_mag = 32'(d); m_neg = 1'b0; m_cnt = (d != 4'd0) ? 1 : 0;
                    m_act = 1'b1; m_ovf = 1'b0; m_lifo.delete();
                end else if (m_cnt == 0 && d == 4'd0) begin
                    m_cnt = 0;
                end else if (m_cnt == 9 || nx > 64'h7FFF_FFFF) m_ovf = 1'b1;
                else begin
                    if (m_lifo.size() == 4) void'(m_lifo.pop_front());
                    m_lifo.push_back(m_mag);
                    m_mag = nx[31:0];
                    m_cnt++;
                end
            end
            3'd3: begin
                if (m_lifo.size() > 0) begin
                    m_mag = m_lifo.pop_back();
                    m_cnt--;
                end else if (m_cnt > 0) begin
                    m_mag = 32'd0; m_cnt = 0;
                end
            end
            3'd4: begin
                if (m_neg && m_mag == 32'h8000_0000) m_ovf = 1'b1;
                else if (m_mag == 32'd0) m_neg = 1'b0;
                else m_neg = !m_neg;
            end
            3'd5, 3'd6: begin
                m_neg = v[31];
                m_mag = v[31] ? (32'd0 - v) : v;
                m_cnt = 0; m_act = 1'b0; m_ovf = 1'b0;
                m_lifo.delete();
            end
            default: m_cnt = m_cnt;
        endcase
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.q   = m_neg ? (32'd0 - m_mag) : m_mag;
        e.cnt = 32'(m_cnt);
        e.act = m_act;
        e.ovf = m_ovf;
        e.ue  = (m_lifo.size() == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Pop the oldest expectation and compare every dut_a output against it.
    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".q"},   number_Q_a,         e.q);
        chk({tag, ".cnt"}, 32'(digit_cnt_a),   e.cnt);
        chk({tag, ".act"}, 32'(entry_active_a), 32'(e.act));
        chk({tag, ".ovf"}, 32'(overflow_a),    32'(e.ovf));
        chk({tag, ".ue"},  32'(undo_empty_a),  32'(e.ue));
    endtask

    // Drive one opcode for one cycle; the expected result is queued at drive time.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] d,
                         input logic [31:0] v);
        model_op(op, d, v);
        sb.push_back(model_exp());
        num_op  = op;
        digit   = d;
        al_C    = (op == 3'd5) ? v : ~v;
        dt_data = (op == 3'd6) ? v : ~v;
        @(posedge Clock);
        #1;
        check_sb(tag);
        num_op = 3'd0;
    endtask

    task automatic enter(input string tag, input int dd[]);
        foreach (dd[i]) do_op(tag, 3'd2, 4'(dd[i]), 32'd0);
    endtask

    initial begin
        // Reset state
        #2 Reset = 1'b0;
        #1;
        chk("rst.q_a", number_Q_a, 32'd0);
        chk("rst.ue_a", 32'(undo_empty_a), 32'd1);
        chk("rst.q_b", number_Q_b, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        model_reset();

        // Asynchronous reset in the middle of an entry
        enter("t1.entry", '{1, 2, 3});
        chk("t1.pre", number_Q_a, 32'd123);
        #3 Reset = 1'b0;
        #1;
        chk("t1.async_q", number_Q_a, 32'd0);
        chk("t1.async_ue", 32'(undo_empty_a), 32'd1);
        chk("t1.async_cnt", 32'(digit_cnt_a), 32'd0);
        chk("t1.async_ue_b", 32'(undo_empty_b), 32'd1);
        model_reset();
        @(posedge Clock); #1;
        chk("t1.held_q", number_Q_a, 32'd0);
        Reset = 1'b1;
        do_op("t1.after", 3'd0, 4'd0, 32'd0);

        // Entry, sign toggle and backspace
        do_op("t2.d1", 3'd2, 4'd1, 32'd0);  chk("t2.q1", number_Q_a, 32'd1);
        do_op("t2.d2", 3'd2, 4'd2, 32'd0);  chk("t2.q12", number_Q_a, 32'd12);
        do_op("t2.d3", 3'd2, 4'd3, 32'd0);  chk("t2.q123", number_Q_a, 32'd123);
        do_op("t2.neg", 3'd4, 4'd0, 32'd0); chk("t2.qm123", number_Q_a, 32'hFFFF_FF85);
        chk("t2.cnt3", 32'(digit_cnt_a), 32'd3);
        do_op("t2.b1", 3'd3, 4'd0, 32'd0);  chk("t2.qm12", number_Q_a, 32'hFFFF_FFF4);
        do_op("t2.b2", 3'd3, 4'd0, 32'd0);
        do_op("t2.b3", 3'd3, 4'd0, 32'd0);  chk("t2.q0", number_Q_a, 32'd0);
        chk("t2.cnt0", 32'(digit_cnt_a), 32'd0);
        do_op("t2.neg0", 3'd4, 4'd0, 32'd0);
        do_op("t2.undef", 3'd7, 4'd3, 32'd0);

        // Undo depth: the fifth backspace takes the empty-history path
        do_op("t3.clr", 3'd1, 4'd0, 32'd0);
        enter("t3.entry", '{1, 2, 3, 4, 5, 6});
        chk("t3.q", number_Q_a, 32'd123456);
        do_op("t3.b1", 3'd3, 4'd0, 32'd0); chk("t3.q12345", number_Q_a, 32'd12345);
        do_op("t3.b2", 3'd3, 4'd0, 32'd0); chk("t3.q1234", number_Q_a, 32'd1234);
        do_op("t3.b3", 3'd3, 4'd0, 32'd0); chk("t3.q123", number_Q_a, 32'd123);
        do_op("t3.b4", 3'd3, 4'd0, 32'd0); chk("t3.q12", number_Q_a, 32'd12);
        chk("t3.ue", 32'(undo_empty_a), 32'd1);
        do_op("t3.b5", 3'd3, 4'd0, 32'd0); chk("t3.q0", number_Q_a, 32'd0);
        chk("t3.cnt0", 32'(digit_cnt_a), 32'd0);

        // Digit-count and magnitude limits
        do_op("t4.clr", 3'd1, 4'd0, 32'd0);
        enter("t4.nine", '{2, 1, 4, 7, 4, 8, 3, 6, 4});
        do_op("t4.a_d0", 3'd2, 4'd0, 32'd0);
        chk("t4.a_q", number_Q_a, 32'd214748364);
        chk("t4.a_ovf", 32'(overflow_a), 32'd1);
        chk("t4.b_q", number_Q_b, 32'd2147483640);
        chk("t4.b_cnt", 32'(digit_cnt_b), 32'd10);
        do_op("t4.clr2", 3'd1, 4'd0, 32'd0);
        enter("t4.max", '{2, 1, 4, 7, 4, 8, 3, 6, 4, 7});
        chk("t4.b_max", number_Q_b, 32'h7FFF_FFFF);
        chk("t4.b_ovf0", 32'(overflow_b), 32'd0);
        chk("t4.b_act", 32'(entry_active_b), 32'd1);
        do_op("t4.more", 3'd2, 4'd0, 32'd0);
        chk("t4.b_hold", number_Q_b, 32'h7FFF_FFFF);
        chk("t4.b_ovf1", 32'(overflow_b), 32'd1);
        do_op("t4.clr3", 3'd1, 4'd0, 32'd0);
        enter("t4.lim", '{2, 1, 4, 7, 4, 8, 3, 6, 4, 8});
        chk("t4.b_lim_q", number_Q_b, 32'd214748364);
        chk("t4.b_lim_ovf", 32'(overflow_b), 32'd1);
        chk("t4.b_lim_cnt", 32'(digit_cnt_b), 32'd9);

        // Loads and the most negative value
        do_op("t5.ldt", 3'd6, 4'd0, 32'h8000_0000);
        chk("t5.q", number_Q_a, 32'h8000_0000);
        chk("t5.act", 32'(entry_active_a), 32'd0);
        do_op("t5.neg", 3'd4, 4'd0, 32'd0);
        chk("t5.ovf", 32'(overflow_a), 32'd1);
        do_op("t5.d7", 3'd2, 4'd7, 32'd0);
        chk("t5.q7", number_Q_a, 32'd7);
        chk("t5.ovf0", 32'(overflow_a), 32'd0);
        do_op("t5.lal", 3'd5, 4'd0, 32'hFFFF_FF85);
        chk("t5.qal", number_Q_a, 32'hFFFF_FF85);
        do_op("t5.neg2", 3'd4, 4'd0, 32'd0);
        chk("t5.q123", number_Q_a, 32'd123);

        // Leading zeros, invalid digit, clear
        do_op("t6.clr", 3'd1, 4'd0, 32'd0);
        do_op("t6.z1", 3'd2, 4'd0, 32'd0);
        do_op("t6.z2", 3'd2, 4'd0, 32'd0);
        do_op("t6.d5", 3'd2, 4'd5, 32'd0);
        chk("t6.q5", number_Q_a, 32'd5);
        chk("t6.cnt1", 32'(digit_cnt_a), 32'd1);
        do_op("t6.d12", 3'd2, 4'd12, 32'd0);
        chk("t6.ovf", 32'(overflow_a), 32'd1);
        do_op("t6.clr2", 3'd1, 4'd0, 32'd0);
        chk("t6.q0", number_Q_a, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
